// File: rtl/evt_buf_ser.sv
// evt_buf_ser: event word buffer (circular FIFO over a synchronous RAM) with a
// serial drain. On a Send rising edge the words present at that moment are
// shifted out MSB first, each optionally preceded by a '1' start bit. Frames
// run back to back with no idle bit between them.
module evt_buf_ser #(
    parameter int unsigned WIDTH = 16,
    parameter int unsigned AW    = 15,
    parameter int unsigned FRAME = 1
) (
    input  logic             Clock,
    input  logic             Reset,
    input  logic [WIDTH-1:0] DataIn,
    input  logic             StrobeIn,
    input  logic             Send,
    input  logic             Clear,
    output logic             DataStream,
    output logic             Busy,
    output logic             Done,
    output logic             Full,
    output logic             Overflow,
    output logic [AW:0]      Count
);

    localparam int unsigned DEPTH = 2 ** AW;
    localparam int unsigned F     = WIDTH + FRAME;
    localparam int unsigned BW    = 6;
    localparam logic [AW:0] DepthC = (AW + 1)'(DEPTH);

    typedef enum logic [1:0] {StIdle, StFetch, StShift, StDone} state_e;

    state_e           state_q;
    logic [AW-1:0]    wr_ptr_q;
    logic [AW-1:0]    rd_ptr_q;
    logic [AW:0]      count_q;
    logic [AW:0]      remain_q;
    logic [BW-1:0]    bit_q;
    logic             send_q;
    logic             busy_q;
    logic             done_q;
    logic             ovf_q;
    logic [WIDTH-1:0] rdata_q;
    logic [WIDTH-1:0] mem [DEPTH];

    logic             wr_en;
    logic             last_bit;
    logic             fetch;
    logic [WIDTH-1:0] shifted;
    logic             stream;

    assign Full     = (count_q == DepthC);
    assign wr_en    = StrobeIn && !Full && !Clear;
    assign last_bit = (bit_q == BW'(F - 1));
    // A fetch happens on entry to a drain and on the last bit of each frame
    // while latched words remain, so the next word lands exactly at the frame
    // boundary.
    assign fetch    = !Clear && ((state_q == StFetch) ||
                      ((state_q == StShift) && last_bit && (remain_q != '0)));

    // RAM: write port and registered read port, no reset (contents don't-care)
    always_ff @(posedge Clock) begin
        if (wr_en) mem[wr_ptr_q] <= DataIn;
        if (fetch) rdata_q <= mem[rd_ptr_q];
    end

    // Frame bit select: start bit first, then the fetched word MSB first
    always_comb begin
        shifted = rdata_q << (bit_q - BW'(FRAME));
        stream  = 1'b0;
        if (state_q == StShift) begin
            if (FRAME != 0 && bit_q == '0) stream = 1'b1;
            else                           stream = shifted[WIDTH-1];
        end
    end

    // Control FSM together with FIFO pointers, occupancy and status flags
    always_ff @(posedge Clock or posedge Reset) begin
        if (Reset) begin
            state_q  <= StIdle;
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
            remain_q <= '0;
            bit_q    <= '0;
            send_q   <= 1'b0;
            busy_q   <= 1'b0;
            done_q   <= 1'b0;
            ovf_q    <= 1'b0;
        end else if (Clear) begin
            state_q  <= StIdle;
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
            remain_q <= '0;
            bit_q    <= '0;
            send_q   <= Send;
            busy_q   <= 1'b0;
            done_q   <= 1'b0;
            ovf_q    <= 1'b0;
        end else begin
            send_q <= Send;
            done_q <= 1'b0;
            if (wr_en) wr_ptr_q <= wr_ptr_q + 1'b1;
            if (fetch) rd_ptr_q <= rd_ptr_q + 1'b1;
            if (StrobeIn && Full) ovf_q <= 1'b1;
            if (wr_en && !fetch)      count_q <= count_q + 1'b1;
            else if (!wr_en && fetch) count_q <= count_q - 1'b1;

            unique case (state_q)
                StIdle: begin
                    // Only words present now belong to this drain
                    if (Send && !send_q && (count_q != '0)) begin
                        state_q  <= StFetch;
                        remain_q <= count_q;
                        busy_q   <= 1'b1;
                    end
                end
                StFetch: begin
                    remain_q <= remain_q - 1'b1;
                    bit_q    <= '0;
                    state_q  <= StShift;
                end
                StShift: begin
                    if (last_bit) begin
                        bit_q <= '0;
                        if (remain_q != '0) begin
                            remain_q <= remain_q - 1'b1;
                        end else begin
                            state_q <= StDone;
                            done_q  <= 1'b1;
                        end
                    end else begin
                        bit_q <= bit_q + 1'b1;
                    end
                end
                StDone: begin
                    state_q <= StIdle;
                    busy_q  <= 1'b0;
                end
                default: state_q <= StIdle;
            endcase
        end
    end

    assign DataStream = stream;
    assign Busy       = busy_q;
    assign Done       = done_q;
    assign Overflow   = ovf_q;
    assign Count      = count_q;

endmodule

// File: tb/tb_evt_buf_ser.sv
// Directed bench for evt_buf_ser with WIDTH=16, AW=3 (depth 8), FRAME=1.
module tb_evt_buf_ser;

    logic        Clock = 1'b0;
    logic        Reset = 1'b1;
    logic [15:0] DataIn = '0;
    logic        StrobeIn = 1'b0;
    logic        Send = 1'b0;
    logic        Clear = 1'b0;
    logic        DataStream;
    logic        Busy;
    logic        Done;
    logic        Full;
    logic        Overflow;
    logic [3:0]  Count;

    int checks = 0;
    int failures = 0;

    logic [15:0] exp_words [16];
    logic [15:0] mid_words [4];

    evt_buf_ser #(.WIDTH(16), .AW(3), .FRAME(1)) dut (
        .Clock      (Clock),
        .Reset      (Reset),
        .DataIn     (DataIn),
        .StrobeIn   (StrobeIn),
        .Send       (Send),
        .Clear      (Clear),
        .DataStream (DataStream),
        .Busy       (Busy),
        .Done       (Done),
        .Full       (Full),
        .Overflow   (Overflow),
        .Count      (Count)
    );

    always #5 Clock = ~Clock;

    initial begin
        #1000000;
        $display("FAIL watchdog: observed=timeout expected=finish");
        $fatal(1, "watchdog expired");
    end

    task automatic tick();
        @(posedge Clock);
        #1;
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic write_word(input logic [15:0] w);
        StrobeIn = 1'b1;
        DataIn   = w;
        tick();
        StrobeIn = 1'b0;
    endtask

    // Drain n words expected in exp_words; optionally write mid_words during
    // the first frame and optionally keep Send high throughout.
    task automatic drain(input string tag, input int n, input int n_mid, input bit hold);
        logic [16:0] got;
        Send = 1'b1;
        tick();
        chk({tag, "_busy_fetch"}, 32'(Busy), 32'd1);
        chk({tag, "_ds_fetch"}, 32'(DataStream), 32'd0);
        if (!hold) Send = 1'b0;
        tick();
        for (int i = 0; i < n; i++) begin
            got = '0;
            for (int b = 0; b < 17; b++) begin
                got = {got[15:0], DataStream};
                if (i == 0 && b < n_mid) begin
                    StrobeIn = 1'b1;
                    DataIn   = mid_words[b];
                end else begin
                    StrobeIn = 1'b0;
                end
                tick();
            end
            chk({tag, "_frame"}, 32'(got), 32'({1'b1, exp_words[i]}));
        end
        StrobeIn = 1'b0;
        chk({tag, "_done"}, 32'(Done), 32'd1);
        chk({tag, "_ds_done"}, 32'(DataStream), 32'd0);
        if (n_mid > 0) chk({tag, "_count_at_done"}, 32'(Count), 32'(n_mid));
        tick();
        chk({tag, "_done_off"}, 32'(Done), 32'd0);
        chk({tag, "_busy_off"}, 32'(Busy), 32'd0);
    endtask

    initial begin
        // Reset state
        tick();
        chk("rst_count", 32'(Count), 32'd0);
        chk("rst_busy", 32'(Busy), 32'd0);
        chk("rst_done", 32'(Done), 32'd0);
        chk("rst_full", 32'(Full), 32'd0);
        chk("rst_ovf", 32'(Overflow), 32'd0);
        chk("rst_ds", 32'(DataStream), 32'd0);
        Reset = 1'b0;
        tick();

        // Two-word drain, contiguous frames
        write_word(16'hA5C3);
        write_word(16'h0001);
        chk("two_count", 32'(Count), 32'd2);
        exp_words[0] = 16'hA5C3;
        exp_words[1] = 16'h0001;
        drain("two", 2, 0, 1'b0);
        chk("two_count_end", 32'(Count), 32'd0);

        // Send edge with empty buffer
        Send = 1'b1;
        tick();
        tick();
        chk("empty_busy", 32'(Busy), 32'd0);
        Send = 1'b0;
        tick();

        // Send held high across Done must not retrigger
        write_word(16'h1234);
        exp_words[0] = 16'h1234;
        drain("hold", 1, 0, 1'b1);
        write_word(16'h5678);
        tick();
        tick();
        chk("hold_busy", 32'(Busy), 32'd0);
        chk("hold_count", 32'(Count), 32'd1);
        Send = 1'b0;
        Clear = 1'b1;
        tick();
        Clear = 1'b0;
        chk("clr_count", 32'(Count), 32'd0);

        // Fill to depth, overflow on the ninth write
        for (int i = 1; i <= 8; i++) begin
            write_word(16'(i * 16'h1111));
            exp_words[i-1] = 16'(i * 16'h1111);
        end
        chk("full_set", 32'(Full), 32'd1);
        chk("full_no_ovf", 32'(Overflow), 32'd0);
        write_word(16'h9999);
        chk("ovf_set", 32'(Overflow), 32'd1);
        chk("ovf_count", 32'(Count), 32'd8);
        drain("full", 8, 0, 1'b0);
        chk("full_clr", 32'(Full), 32'd0);
        chk("ovf_sticky", 32'(Overflow), 32'd1);
        Clear = 1'b1;
        tick();
        Clear = 1'b0;
        chk("ovf_cleared", 32'(Overflow), 32'd0);

        // Writes during a drain stay for the next drain
        write_word(16'h0F0F);
        write_word(16'hF00F);
        write_word(16'h8001);
        exp_words[0] = 16'h0F0F;
        exp_words[1] = 16'hF00F;
        exp_words[2] = 16'h8001;
        mid_words[0] = 16'hBEEF;
        mid_words[1] = 16'h7E57;
        drain("mid", 3, 2, 1'b0);
        exp_words[0] = 16'hBEEF;
        exp_words[1] = 16'h7E57;
        drain("mid2", 2, 0, 1'b0);
        chk("mid2_count", 32'(Count), 32'd0);

        // Pointer wrap over several rounds
        for (int r = 0; r < 3; r++) begin
            for (int k = 0; k < 8; k++) begin
                exp_words[k] = 16'(r * 4096 + k * 273 + 5);
                write_word(exp_words[k]);
            end
            drain("wrap", 8, 0, 1'b0);
        end
        chk("wrap_count", 32'(Count), 32'd0);

        // Asynchronous reset during the start bit
        write_word(16'hFFFF);
        write_word(16'hFFFF);
        Send = 1'b1;
        tick();
        Send = 1'b0;
        tick();
        chk("ar_start_bit", 32'(DataStream), 32'd1);
        #2;
        Reset = 1'b1;
        #1;
        chk("ar_ds", 32'(DataStream), 32'd0);
        chk("ar_busy", 32'(Busy), 32'd0);
        chk("ar_count", 32'(Count), 32'd0);
        #1;
        Reset = 1'b0;
        for (int i = 0; i < 20; i++) begin
            tick();
            if (Done !== 1'b0 || DataStream !== 1'b0 || Busy !== 1'b0) begin
                chk("ar_quiet", 32'({Done, DataStream, Busy}), 32'd0);
            end
        end
        chk("ar_quiet_end", 32'({Done, DataStream, Busy}), 32'd0);
        write_word(16'h4321);
        exp_words[0] = 16'h4321;
        drain("ar_after", 1, 0, 1'b0);

        // Synchronous Clear mid-drain after an overflow
        for (int i = 0; i < 9; i++) write_word(16'hC3C3);
        chk("cl_ovf", 32'(Overflow), 32'd1);
        Send = 1'b1;
        tick();
        Send = 1'b0;
        for (int i = 0; i < 5; i++) tick();
        Clear = 1'b1;
        tick();
        Clear = 1'b0;
        chk("cl_ds", 32'(DataStream), 32'd0);
        chk("cl_busy", 32'(Busy), 32'd0);
        chk("cl_count", 32'(Count), 32'd0);
        chk("cl_ovf_clr", 32'(Overflow), 32'd0);
        chk("cl_done", 32'(Done), 32'd0);
        for (int i = 0; i < 20; i++) begin
            tick();
            if (Done !== 1'b0 || Busy !== 1'b0) chk("cl_quiet", 32'({Done, Busy}), 32'd0);
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
